alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a multiply/divide sequencer: decodes aluop/funct into
// an ALU code and runs a fixed-latency busy window for MDU operations.
module alu_ctrl_seq #(
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [2:0]        aluop,
    input  logic [5:0]        funct,
    input  logic              flush,
    output logic              stall,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              illegal,
    output logic              mdu_start,
    output logic [1:0]        mdu_op,
    output logic              busy,
    output logic              hilo_we
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alucontrol_q, alucontrol_d;
    logic              illegal_q, illegal_d;
    logic              mdu_start_q, mdu_start_d;
    logic [1:0]        mdu_op_q, mdu_op_d;

    logic [3:0] dec_ctrl;
    logic       dec_ill;
    logic       dec_mdu;
    logic       dec_hilo_dep;
    logic       accept;

    // Instruction decode; dec_hilo_dep marks requests that must wait for HI/LO.
    always_comb begin
        dec_ctrl     = OP_ADD;
        dec_ill      = 1'b0;
        dec_mdu      = 1'b0;
        dec_hilo_dep = 1'b0;
        unique case (aluop)
            3'b000: dec_ctrl = OP_ADD;
            3'b001: dec_ctrl = OP_SUB;
            3'b011: dec_ctrl = OP_OR;
            3'b100: dec_ctrl = OP_AND;
            3'b101: dec_ctrl = OP_SLT;
            3'b110: dec_ctrl = OP_XOR;
            3'b111: dec_ctrl = OP_SLTU;
            default: begin
                unique case (funct)
                    6'b100000, 6'b100001: dec_ctrl = OP_ADD;
                    6'b100010, 6'b100011: dec_ctrl = OP_SUB;
                    6'b100100: dec_ctrl = OP_AND;
                    6'b100101: dec_ctrl = OP_OR;
                    6'b100110: dec_ctrl = OP_XOR;
                    6'b100111: dec_ctrl = OP_NOR;
                    6'b101010: dec_ctrl = OP_SLT;
                    6'b101011: dec_ctrl = OP_SLTU;
                    6'b000000: dec_ctrl = OP_SLL;
                    6'b000010: dec_ctrl = OP_SRL;
                    6'b000011: dec_ctrl = OP_SRA;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        dec_mdu      = 1'b1;
                        dec_hilo_dep = 1'b1;
                    end
                    6'b010000, 6'b010010: dec_hilo_dep = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    assign busy    = (state_q == S_BUSY);
    assign stall   = reset & in_valid & busy & dec_hilo_dep;
    assign accept  = in_valid & ~stall & ~flush;
    assign hilo_we = busy & (cnt_q == CNT_ONE) & ~flush;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = accept;
        alucontrol_d = alucontrol_q;
        illegal_d    = illegal_q;
        mdu_start_d  = 1'b0;
        mdu_op_d     = mdu_op_q;

        if (accept) begin
            alucontrol_d = CTRL_W'(dec_ctrl);
            illegal_d    = dec_ill;
            mdu_op_d     = dec_mdu ? funct[1:0] : 2'b00;
        end

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept && dec_mdu) begin
                        state_d     = S_BUSY;
                        cnt_d       = funct[1] ? DIV_CNT : MUL_CNT;
                        mdu_start_d = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            alucontrol_q <= '0;
            illegal_q    <= 1'b0;
            mdu_start_q  <= 1'b0;
            mdu_op_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            alucontrol_q <= alucontrol_d;
            illegal_q    <= illegal_d;
            mdu_start_q  <= mdu_start_d;
            mdu_op_q     <= mdu_op_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alucontrol = alucontrol_q;
    assign illegal    = illegal_q;
    assign mdu_start  = mdu_start_q;
    assign mdu_op     = mdu_op_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: scoreboarded decode results plus directed timing checks
// of the MDU busy window, stalls, flush and asynchronous reset.
module tb_alu_ctrl_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, flush;
    logic [2:0] aluop;
    logic [5:0] funct;
    logic       stall, out_valid, illegal, mdu_start, busy, hilo_we;
    logic [3:0] alucontrol;
    logic [1:0] mdu_op;

    logic       in_valid1, flush1;
    logic [2:0] aluop1;
    logic [5:0] funct1;
    logic       stall1, out_valid1, illegal1, mdu_start1, busy1, hilo_we1;
    logic [3:0] alucontrol1;
    logic [1:0] mdu_op1;

    alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(4), .DIV_LAT(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .aluop(aluop), .funct(funct),
        .flush(flush), .stall(stall), .out_valid(out_valid), .alucontrol(alucontrol),
        .illegal(illegal), .mdu_start(mdu_start), .mdu_op(mdu_op), .busy(busy),
        .hilo_we(hilo_we)
    );

    alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(1), .DIV_LAT(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .aluop(aluop1), .funct(funct1),
        .flush(flush1), .stall(stall1), .out_valid(out_valid1), .alucontrol(alucontrol1),
        .illegal(illegal1), .mdu_start(mdu_start1), .mdu_op(mdu_op1), .busy(busy1),
        .hilo_we(hilo_we1)
    );

    typedef struct packed {
        logic [3:0] ctrl;
        logic       ill;
        logic       mdu;
        logic [1:0] op;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   hilo_cnt = 0;
    int   hilo_cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Hand-written decode table.
    function automatic exp_t model(input logic [2:0] op, input logic [5:0] f);
        exp_t e;
        e = '0;
        case (op)
            3'd0: e.ctrl = 4'd0;
            3'd1: e.ctrl = 4'd1;
            3'd3: e.ctrl = 4'd3;
            3'd4: e.ctrl = 4'd2;
            3'd5: e.ctrl = 4'd4;
            3'd6: e.ctrl = 4'd6;
            3'd7: e.ctrl = 4'd8;
            default: begin
                case (f)
                    6'd32, 6'd33: e.ctrl = 4'd0;
                    6'd34, 6'd35: e.ctrl = 4'd1;
                    6'd36: e.ctrl = 4'd2;
                    6'd37: e.ctrl = 4'd3;
                    6'd38: e.ctrl = 4'd6;
                    6'd39: e.ctrl = 4'd7;
                    6'd42: e.ctrl = 4'd4;
                    6'd43: e.ctrl = 4'd8;
                    6'd0:  e.ctrl = 4'd5;
                    6'd2:  e.ctrl = 4'd9;
                    6'd3:  e.ctrl = 4'd10;
                    6'd24: begin e.mdu = 1'b1; e.op = 2'd0; end
                    6'd25: begin e.mdu = 1'b1; e.op = 2'd1; end
                    6'd26: begin e.mdu = 1'b1; e.op = 2'd2; end
                    6'd27: begin e.mdu = 1'b1; e.op = 2'd3; end
                    6'd16, 6'd18: e.ctrl = 4'd0;
                    default: e.ill = 1'b1;
                endcase
            end
        endcase
        return e;
    endfunction

    // Monitor: pops one expectation per out_valid and counts HI/LO strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("alucontrol", 32'(alucontrol), 32'(e.ctrl));
                    check("illegal", 32'(illegal), 32'(e.ill));
                    check("mdu_start", 32'(mdu_start), 32'(e.mdu));
                    if (e.mdu) check("mdu_op", 32'(mdu_op), 32'(e.op));
                end
            end
            if (hilo_we)  hilo_cnt++;
            if (hilo_we1) hilo_cnt1++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait out any stall (bounded) and log its expectation.
    task automatic send(input logic [2:0] op, input logic [5:0] f, input int max_wait,
                        output int n);
        in_valid = 1'b1;
        aluop    = op;
        funct    = f;
        n        = 0;
        #1;
        while (stall && n < max_wait) begin
            tick();
            n++;
        end
        if (stall) begin
            check("stall_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(model(op, f));
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int h0;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; aluop = 3'd0; funct = 6'd0;
        in_valid1 = 1'b0; flush1 = 1'b0; aluop1 = 3'd0; funct1 = 6'd0;

        // Reset state, with a request held on the inputs.
        repeat (2) tick();
        in_valid = 1'b1; aluop = 3'b010; funct = 6'h12;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alucontrol", 32'(alucontrol), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_mdu_start", 32'(mdu_start), 32'd0);
        check("rst_mdu_op", 32'(mdu_op), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hilo_we", 32'(hilo_we), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        tick();
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Sweep every aluop, then every R-type funct.
        for (int a = 0; a < 8; a++) send(3'(a), 6'h20, 40, n);
        for (int f = 0; f < 64; f++) send(3'b010, 6'(f), 40, n);
        wait_idle();

        // multu: start pulse, 4-cycle busy window, strobe in the last cycle.
        send(3'b010, 6'h19, 0, n);
        check("multu_start", 32'(mdu_start), 32'd1);
        check("multu_op", 32'(mdu_op), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("multu_busy_T%0d", k), 32'(busy), 32'(k <= 4));
            check($sformatf("multu_hilo_T%0d", k), 32'(hilo_we), 32'(k == 4));
            if (k < 5) tick();
        end

        // div, unrelated add proceeds, mflo waits for the end of the window.
        send(3'b010, 6'h1a, 0, n);
        send(3'b000, 6'h00, 40, n);
        check("add_not_stalled", 32'(n), 32'd0);
        send(3'b010, 6'h12, 40, n);
        check("mflo_stall_cycles", 32'(n), 32'd31);
        check("mflo_busy_after", 32'(busy), 32'd0);

        // Flush in the 3rd busy cycle of a div also blocks that cycle's request.
        send(3'b010, 6'h1a, 0, n);
        tick();
        tick();
        h0 = hilo_cnt;
        flush = 1'b1; in_valid = 1'b1; aluop = 3'b000; funct = 6'h00;
        #1;
        check("flush_busy_before", 32'(busy), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy_after", 32'(busy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (40) tick();
        check("flush_no_hilo", 32'(hilo_cnt), 32'(h0));

        // Asynchronous reset in the 5th busy cycle of a div.
        send(3'b010, 6'h1a, 0, n);
        repeat (4) tick();
        h0 = hilo_cnt;
        in_valid = 1'b1; aluop = 3'b010; funct = 6'h10;
        #1;
        check("mfhi_stalled_busy", 32'(stall), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_alucontrol", 32'(alucontrol), 32'd0);
        check("arst_mdu_op", 32'(mdu_op), 32'd0);
        check("arst_mdu_start", 32'(mdu_start), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hilo_we", 32'(hilo_we), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b1; in_valid = 1'b0;
        repeat (40) tick();
        check("arst_no_hilo", 32'(hilo_cnt), 32'(h0));
        send(3'b000, 6'h00, 0, n);
        send(3'b010, 6'h2b, 0, n);
        send(3'b110, 6'h00, 0, n);
        repeat (2) tick();

        // MUL_LAT=1: back-to-back mult stalls exactly one cycle, two strobes.
        h0 = hilo_cnt1;
        in_valid1 = 1'b1; aluop1 = 3'b010; funct1 = 6'h18;
        tick();
        check("m1_start_a", 32'(mdu_start1), 32'd1);
        check("m1_busy_a", 32'(busy1), 32'd1);
        check("m1_hilo_a", 32'(hilo_we1), 32'd1);
        check("m1_stall_a", 32'(stall1), 32'd1);
        tick();
        check("m1_busy_gap", 32'(busy1), 32'd0);
        check("m1_stall_gap", 32'(stall1), 32'd0);
        check("m1_valid_gap", 32'(out_valid1), 32'd0);
        tick();
        in_valid1 = 1'b0;
        check("m1_start_b", 32'(mdu_start1), 32'd1);
        check("m1_valid_b", 32'(out_valid1), 32'd1);
        check("m1_hilo_b", 32'(hilo_we1), 32'd1);
        tick();
        check("m1_busy_end", 32'(busy1), 32'd0);
        check("m1_hilo_pulses", 32'(hilo_cnt1 - h0), 32'd2);

        // Flush on the counter=1 cycle suppresses the strobe.
        h0 = hilo_cnt1;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0; flush1 = 1'b1;
        #1;
        check("m1_flush_busy", 32'(busy1), 32'd1);
        check("m1_flush_hilo", 32'(hilo_we1), 32'd0);
        tick();
        flush1 = 1'b0;
        check("m1_flush_idle", 32'(busy1), 32'd0);
        repeat (3) tick();
        check("m1_flush_no_pulse", 32'(hilo_cnt1), 32'(h0));

        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
